// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: N-digit seven-segment driver with shadow load, leading-zero
// suppression, per-digit blanking/decimal points and time-multiplexed scan mode.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    mode,
  input  logic                    lz_en,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [NUM_DIGITS-1:0]   dp_n,
  output logic [IDX_W-1:0]        digit_idx
);
  localparam int DIV_W = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [4*NUM_DIGITS-1:0] sh_value_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q;
  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dpn_q, dpn_d;
  logic                    div_wrap, upper_zero, dark;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  endfunction
  assign div_wrap = div_q == DIV_W'(REFRESH_DIV - 1);
  // Walk from the top digit down so upper_zero means "this nibble and all above are 0".
  always_comb begin
    hex_d = '1;
    dpn_d = '1;
    upper_zero = 1'b1;
    dark = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (sh_value_q[4*i +: 4] == 4'd0);
      dark = sh_blank_q[i] | (lz_en & (i > 0) & upper_zero) | (mode & (idx_q != IDX_W'(i)));
      hex_d[7*i +: 7] = dark ? 7'h7F : dec(sh_value_q[4*i +: 4]);
      dpn_d[i] = dark | ~sh_dp_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value_q <= '0;
      sh_dp_q <= '0;
      sh_blank_q <= '0;
      div_q <= '0;
      idx_q <= '0;
      hex_q <= '1;
      dpn_q <= '1;
    end else begin
      if (load) begin
        sh_value_q <= value;
        sh_dp_q <= dp_mask;
        sh_blank_q <= blank_mask;
      end
      div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      hex_q <= hex_d;
      dpn_q <= dpn_d;
    end
  end
  assign hex = hex_q;
  assign dp_n = dpn_q;
  assign digit_idx = idx_q;
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised seven-segment display driver that generalises the fixed four-digit selector into an N-digit controller with an internal hex decoder, load-strobed shadow register, leading-zero suppression, per-digit blanking and decimal points, and an automatic time-multiplexed scan mode. It sits between the HPS/fabric register interface (or any producer of a packed hex value) and the board's HEX display pins. It runs from a single clock.

## Interface
- NUM_DIGITS, 4, number of digits driven (≥1)
- REFRESH_DIV, 50000, clock cycles each digit stays active in scan mode (≥1)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  capture strobe for value/dp_mask/blank_mask
- value  in  4*NUM_DIGITS  packed hex nibbles, digit i = value[4i+3:4i]
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i
- blank_mask  in  NUM_DIGITS  1 = digit i forced dark
- mode  in  1  0 = static (all digits driven), 1 = scan (one digit at a time)
- lz_en  in  1  leading-zero suppression enable (live, not shadowed)
- hex  out  7*NUM_DIGITS  active-low segments, digit i = hex[7i+6:7i], bit order gfedcba
- dp_n  out  NUM_DIGITS  active-low decimal points
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  currently active scan digit

## Operation
- Shadow registers sh_value, sh_dp, sh_blank load from inputs on any edge with load=1; hold otherwise.
- Decoder, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Blank pattern = 7'b1111111, dp off = 1.
- Digit i dark when: sh_blank[i]=1; or lz_en=1, i>0, and every nibble j≥i of sh_value is 0 (digit 0 never suppressed).
- Static mode: every non-dark digit shows its decoded nibble and its dp; all other digits dark.
- Scan mode: only digit digit_idx is driven (subject to dark rules); all others dark, dp off.
- Scan counter: div_cnt counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 wraps to 0 and digit_idx advances, NUM_DIGITS-1 → 0. Counter runs in both modes; mode change does not reset it.
- NUM_DIGITS=1: digit_idx stays 0.

## Timing
- Reset (synchronous, priority over load): sh_value=0, sh_dp=0, sh_blank=0, div_cnt=0, digit_idx=0, hex all 1s, dp_n all 1s.
- hex/dp_n are registered from shadow + live controls: load at edge k → shadow updated at k → hex reflects new data after edge k+1 (2-cycle latency from load sample to pin).
- mode/lz_en changes seen at edge k appear on hex after edge k (1-cycle latency).
- digit_idx is a register; hex in scan mode follows digit_idx with one cycle of lag (digit_idx changes at edge k, hex switches digit at edge k+1).
- load held high: shadow tracks inputs every cycle.
- load concurrent with digit advance: both take effect; no lost update.
- Reset mid-scan: next edge returns to digit 0, div_cnt 0, outputs blank for that cycle.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4: reset 2 cycles → hex=28'hFFFFFFF, dp_n=4'hF, digit_idx=0; two edges after release, static, lz_en=0 → all digits 1000000.
- Static, load value=16'h12AF, dp_mask=4'b0100 → two edges later digit0=0001110, digit1=0001000, digit2=0100100 with dp_n[2]=0, digit3=1111001.
- lz_en=1, load value=16'h0070 → digit0=1000000, digit1=1111000, digits 2,3 dark; value=16'h0000 → only digit0 shows 0.
- Scan mode, value=16'h4321: digit_idx steps 0,1,2,3,0 every 4 cycles; hex shows exactly one non-blank digit matching decode of that nibble one cycle after each step.
- blank_mask=4'b0010 with dp_mask=4'b0010 → digit1 dark and dp_n[1]=1 in both modes.
- Assert reset during scan at digit_idx=2 → next edge digit_idx=0, all outputs blank; load asserted same cycle as reset is ignored (shadow = 0).
